// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - ASCII constants, byte classes and transmit FSM states for uart_digit_buffer
package uart_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Cycles the transmit FSM waits for Tx_Busy to rise before giving up.
  localparam int TX_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    BYTE_DIGIT,
    BYTE_BS,
    BYTE_ESC,
    BYTE_CR,
    BYTE_OTHER
  } byte_kind_t;

  function automatic byte_kind_t classify(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9) return BYTE_DIGIT;
    case (b)
      ASCII_BS:  return BYTE_BS;
      ASCII_ESC: return BYTE_ESC;
      ASCII_CR:  return BYTE_CR;
      default:   return BYTE_OTHER;
    endcase
  endfunction

  // Thermometer code: d lit LEDs for d=0..8, all eight lit for 9.
  function automatic logic [7:0] level_code(input logic [3:0] d);
    logic [8:0] t;
    t = (9'd1 << d) - 9'd1;
    if (d > 4'd8) return 8'hFF;
    return t[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and push-on-full-with-pop support
// Ports:
//   Clk_100M, Reset_n   clock, asynchronous active-low reset (clears pointers and count)
//   Push, Push_Data     write request and data; accepted when not full or when popping
//   Pop, Pop_Data       read request; Pop_Data is the current head
//   Empty, Full         occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk_100M,
  input  logic             Reset_n,
  input  logic             Push,
  input  logic [WIDTH-1:0] Push_Data,
  input  logic             Pop,
  output logic [WIDTH-1:0] Pop_Data,
  output logic             Empty,
  output logic             Full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign Empty    = (count == '0);
  assign Full     = (count == (AW+1)'(DEPTH));
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_ok  = Push && (!Full || Pop);
  assign pop_ok   = Pop && !Empty;
  assign Pop_Data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (push_ok) mem[wr_ptr] <= Push_Data;
  end

endmodule

// File: rtl/uart_digit_buffer.sv
// rtl/uart_digit_buffer.sv - BCD digit entry buffer driven by received UART bytes, with optional echo
// Ports:
//   Clk_100M, Reset_n        clock, asynchronous active-low reset
//   Rx_Data, Rx_Valid        received byte and its one-cycle strobe
//   Tx_Busy                  transmitter busy flag
//   Tx_Data, Tx_Start        echo byte and one-cycle transmit request
//   Digits, Digit_Count      live entry buffer (nibble 0 newest) and number of digits entered
//   Value, Commit            last committed buffer and its one-cycle update pulse
//   Level                    thermometer code of the most recent digit
//   Err                      one-cycle pulse on an unrecognised byte
//   Overflow                 sticky flag, an echo byte was dropped
module uart_digit_buffer
  import uart_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ECHO_EN    = 1,
  parameter int ECHO_DEPTH = 4
) (
  input  logic                         Clk_100M,
  input  logic                         Reset_n,
  input  logic [7:0]                   Rx_Data,
  input  logic                         Rx_Valid,
  input  logic                         Tx_Busy,
  output logic [7:0]                   Tx_Data,
  output logic                         Tx_Start,
  output logic [4*DIGITS-1:0]          Digits,
  output logic [$clog2(DIGITS+1)-1:0]  Digit_Count,
  output logic [4*DIGITS-1:0]          Value,
  output logic                         Commit,
  output logic [7:0]                   Level,
  output logic                         Err,
  output logic                         Overflow
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  byte_kind_t kind;
  logic [3:0] rx_digit;

  assign kind     = classify(Rx_Data);
  // '0'..'9' carry their BCD value in the low nibble.
  assign rx_digit = Rx_Data[3:0];

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      Digits      <= '0;
      Digit_Count <= '0;
      Value       <= '0;
      Level       <= '0;
      Commit      <= 1'b0;
      Err         <= 1'b0;
    end else begin
      Commit <= 1'b0;
      Err    <= 1'b0;
      if (Rx_Valid) begin
        case (kind)
          BYTE_DIGIT: begin
            // Shifting the whole vector drops the oldest nibble off the top.
            Digits <= (Digits << 4) | DW'(rx_digit);
            if (Digit_Count != CW'(DIGITS)) Digit_Count <= Digit_Count + 1'b1;
            Level <= level_code(rx_digit);
          end
          BYTE_BS: begin
            if (Digit_Count != '0) begin
              Digits      <= Digits >> 4;
              Digit_Count <= Digit_Count - 1'b1;
            end
          end
          BYTE_ESC: begin
            Digits      <= '0;
            Digit_Count <= '0;
          end
          BYTE_CR: begin
            Value       <= Digits;
            Commit      <= 1'b1;
            Digits      <= '0;
            Digit_Count <= '0;
          end
          default: begin
            Err <= 1'b1;
          end
        endcase
      end
    end
  end

  if (ECHO_EN != 0) begin : g_echo
    logic       push;
    logic       pop;
    logic       empty;
    logic       full;
    logic [7:0] push_data;
    logic [7:0] head;
    tx_state_t  state;
    tx_state_t  state_nx;
    logic [3:0] timer;
    logic [3:0] timer_nx;
    logic       start_nx;

    assign push      = Rx_Valid;
    assign push_data = (kind == BYTE_OTHER) ? ASCII_QMARK : Rx_Data;

    sync_fifo #(
      .WIDTH (8),
      .DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
      .Clk_100M  (Clk_100M),
      .Reset_n   (Reset_n),
      .Push      (push),
      .Push_Data (push_data),
      .Pop       (pop),
      .Pop_Data  (head),
      .Empty     (empty),
      .Full      (full)
    );

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
        Overflow <= 1'b0;
      end else if (push && full && !pop) begin
        Overflow <= 1'b1;
      end
    end

    // Tx_Data is only reloaded on a new start, so it stays stable through the transfer.
    always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
        state    <= IDLE;
        timer    <= '0;
        Tx_Start <= 1'b0;
        Tx_Data  <= '0;
      end else begin
        state    <= state_nx;
        timer    <= timer_nx;
        Tx_Start <= start_nx;
        if (start_nx) Tx_Data <= head;
      end
    end

    always_comb begin
      state_nx = state;
      timer_nx = timer;
      start_nx = 1'b0;
      pop      = 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !Tx_Busy) begin
            pop      = 1'b1;
            start_nx = 1'b1;
            timer_nx = '0;
            state_nx = WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // The Tx_Start cycle is the first of the TX_TIMEOUT waiting cycles.
          if (Tx_Busy) begin
            state_nx = WAIT_DONE;
          end else if (timer == 4'(TX_TIMEOUT - 1)) begin
            state_nx = IDLE;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!Tx_Busy) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end else begin : g_no_echo
    assign Tx_Start = 1'b0;
    assign Tx_Data  = '0;
    assign Overflow = 1'b0;
  end

endmodule

// File: tb/tb_uart_digit_buffer.sv
// tb/tb_uart_digit_buffer.sv - directed self-checking bench for uart_digit_buffer
module tb_uart_digit_buffer;

  logic        Clk_100M = 1'b0;
  logic        Reset_n;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Tx_Busy = 1'b0;
  logic [7:0]  Tx_Data;
  logic        Tx_Start;
  logic [15:0] Digits;
  logic [2:0]  Digit_Count;
  logic [15:0] Value;
  logic        Commit;
  logic [7:0]  Level;
  logic        Err;
  logic        Overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_mode = 0;   // 0 responder, 1 held high, 2 never busy, 3 busy forever after a start
  int busy_cnt = 0;
  int commit_cnt = 0;
  int err_cnt = 0;
  logic [7:0] tx_log[$];
  int start_cyc[$];
  logic [7:0] exp_log[$];

  always #5 Clk_100M = ~Clk_100M;

  uart_digit_buffer #(
    .DIGITS     (4),
    .ECHO_EN    (1),
    .ECHO_DEPTH (4)
  ) dut (
    .Clk_100M    (Clk_100M),
    .Reset_n     (Reset_n),
    .Rx_Data     (Rx_Data),
    .Rx_Valid    (Rx_Valid),
    .Tx_Busy     (Tx_Busy),
    .Tx_Data     (Tx_Data),
    .Tx_Start    (Tx_Start),
    .Digits      (Digits),
    .Digit_Count (Digit_Count),
    .Value       (Value),
    .Commit      (Commit),
    .Level       (Level),
    .Err         (Err),
    .Overflow    (Overflow)
  );

  always @(posedge Clk_100M) cyc <= cyc + 1;

  always @(negedge Clk_100M) begin
    if (Tx_Start) begin
      tx_log.push_back(Tx_Data);
      start_cyc.push_back(cyc);
    end
    if (Commit) commit_cnt++;
    if (Err) err_cnt++;
    case (busy_mode)
      0: begin
        if (Tx_Start) busy_cnt = 4;
        else if (busy_cnt > 0) busy_cnt--;
        Tx_Busy = (busy_cnt > 0);
      end
      1: begin Tx_Busy = 1'b1; busy_cnt = 0; end
      2: begin Tx_Busy = 1'b0; busy_cnt = 0; end
      default: begin
        if (Tx_Start) Tx_Busy = 1'b1;
        busy_cnt = 0;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, tx_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), tx_log[i], exp_log[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk_100M);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clk_100M);
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    @(negedge Clk_100M);
    Rx_Valid = 1'b0;
  endtask

  task automatic set_mode(input int m);
    @(posedge Clk_100M);
    #1 busy_mode = m;
  endtask

  task automatic do_reset();
    @(negedge Clk_100M);
    Reset_n = 1'b0;
    idle(2);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n  = 1'b0;
    Rx_Valid = 1'b1;
    Rx_Data  = 8'h35;
    idle(3);
    check("rst_digits", Digits, 16'h0);
    check("rst_count", Digit_Count, 3'd0);
    check("rst_value", Value, 16'h0);
    check("rst_level", Level, 8'h0);
    check("rst_commit", Commit, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_start", Tx_Start, 1'b0);
    check("rst_txdata", Tx_Data, 8'h0);
    check("rst_ovf", Overflow, 1'b0);
    Reset_n  = 1'b1;
    Rx_Valid = 1'b0;
    idle(1);
    check("rst_rx_ignored", Digits, 16'h0);
    check("rst_no_echo", tx_log.size(), 0);

    // first digit: latency 1 on state, Tx_Start two cycles after Rx_Valid
    send(8'h31);
    check("d1_digits", Digits, 16'h0001);
    check("d1_count", Digit_Count, 3'd1);
    check("d1_level", Level, 8'h01);
    check("d1_start_early", Tx_Start, 1'b0);
    idle(1);
    check("d1_start", Tx_Start, 1'b1);
    check("d1_txdata", Tx_Data, 8'h31);
    idle(10);
    send(8'h32); idle(10);
    send(8'h33); idle(10);
    send(8'h34); idle(10);
    check("d4_digits", Digits, 16'h1234);
    check("d4_count", Digit_Count, 3'd4);
    check("d4_level", Level, 8'h0F);
    send(8'h35); idle(10);
    check("d5_digits", Digits, 16'h2345);
    check("d5_count", Digit_Count, 3'd4);
    check("d5_level", Level, 8'h1F);

    send(8'h1B); idle(10);
    check("esc_digits", Digits, 16'h0);
    check("esc_count", Digit_Count, 3'd0);
    check("esc_value", Value, 16'h0);
    check("esc_level", Level, 8'h1F);

    commit_cnt = 0;
    tx_log.delete();
    send(8'h37); idle(10);
    send(8'h38); idle(10);
    check("78_digits", Digits, 16'h0078);
    check("78_level", Level, 8'hFF);
    send(8'h08); idle(10);
    check("bs_digits", Digits, 16'h0007);
    check("bs_count", Digit_Count, 3'd1);
    send(8'h0D); idle(10);
    check("cr_value", Value, 16'h0007);
    check("cr_digits", Digits, 16'h0);
    check("cr_count", Digit_Count, 3'd0);
    check("cr_commits", commit_cnt, 1);
    send(8'h08); idle(10);
    check("bs0_digits", Digits, 16'h0);
    check("bs0_count", Digit_Count, 3'd0);
    check("bs0_value", Value, 16'h0007);
    check("bs0_commits", commit_cnt, 1);
    exp_log = '{8'h37, 8'h38, 8'h08, 8'h0D, 8'h08};
    check_log("echo_edit");

    err_cnt = 0;
    tx_log.delete();
    send(8'h39); idle(10);
    check("d9_level", Level, 8'hFF);
    send(8'h78); idle(10);
    check("x_err", err_cnt, 1);
    check("x_digits", Digits, 16'h0009);
    check("x_count", Digit_Count, 3'd1);
    exp_log = '{8'h39, 8'h3F};
    check_log("echo_err");

    // overflow: six digits into a 4-deep FIFO while the transmitter is busy
    check("ovf_pre", Overflow, 1'b0);
    set_mode(1);
    idle(2);
    tx_log.delete();
    for (int i = 1; i <= 6; i++) send(8'h30 + 8'(i));
    check("ovf_set", Overflow, 1'b1);
    check("ovf_digits", Digits, 16'h3456);
    check("ovf_count", Digit_Count, 3'd4);
    check("ovf_nosend", tx_log.size(), 0);
    set_mode(0);
    idle(60);
    exp_log = '{8'h31, 8'h32, 8'h33, 8'h34};
    check_log("echo_ovf");
    check("ovf_sticky", Overflow, 1'b1);

    do_reset();
    check("ovf_clr", Overflow, 1'b0);

    // push and pop in the same cycle on a full FIFO
    set_mode(1);
    idle(2);
    tx_log.delete();
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i));
    check("full_noovf", Overflow, 1'b0);
    set_mode(0);
    send(8'h35);
    check("pp_noovf", Overflow, 1'b0);
    idle(60);
    exp_log = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    check_log("echo_pp");
    check("pp_digits", Digits, 16'h2345);

    // timeout when Tx_Busy never rises
    set_mode(2);
    idle(2);
    tx_log.delete();
    start_cyc.delete();
    send(8'h31);
    send(8'h32);
    idle(50);
    check("to_starts", start_cyc.size(), 2);
    if (start_cyc.size() >= 2)
      check("to_gap", start_cyc[1] - start_cyc[0], 16);
    exp_log = '{8'h31, 8'h32};
    check_log("echo_to");

    // reset while in WAIT_DONE with three bytes queued
    set_mode(3);
    idle(2);
    tx_log.delete();
    for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i));
    idle(10);
    check("wd_started", tx_log.size(), 1);
    @(negedge Clk_100M);
    Reset_n = 1'b0;
    #1;
    check("ar_digits", Digits, 16'h0);
    check("ar_count", Digit_Count, 3'd0);
    check("ar_value", Value, 16'h0);
    check("ar_level", Level, 8'h0);
    check("ar_txdata", Tx_Data, 8'h0);
    check("ar_start", Tx_Start, 1'b0);
    check("ar_ovf", Overflow, 1'b0);
    set_mode(0);
    idle(3);
    Reset_n = 1'b1;
    tx_log.delete();
    idle(60);
    check("ar_nosend", tx_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
